// File: rtl/alu_ram_arbiter_if.sv
// Request/response and RAM-side signals shared by the ALU RAM arbiter and its neighbours.
// Handshake: a request transfers on a cycle where *_req_valid & *_req_ready are both high; valid and payload
// stay stable until that cycle. Responses are single-cycle pulses with no backpressure.
interface alu_ram_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              dp_req_valid;
   logic              dp_req_ready;
   logic              dp_req_we;
   logic [ADDR_W-1:0] dp_req_addr;
   logic [DATA_W-1:0] dp_req_wdata;
   logic              dp_rsp_valid;
   logic [DATA_W-1:0] dp_rsp_data;
   logic              cfg_req_valid;
   logic              cfg_req_ready;
   logic              cfg_req_we;
   logic [ADDR_W-1:0] cfg_req_addr;
   logic [DATA_W-1:0] cfg_req_wdata;
   logic              cfg_rsp_valid;
   logic [DATA_W-1:0] cfg_rsp_data;
   logic              clr_start;
   logic              busy;
   logic              fsm_state;
   logic              ram_wea;
   logic [ADDR_W-1:0] ram_addra;
   logic [DATA_W-1:0] ram_dina;
   logic [ADDR_W-1:0] ram_addrb;
   logic [DATA_W-1:0] ram_doutb;

   modport slave (
      input  dp_req_valid, dp_req_we, dp_req_addr, dp_req_wdata,
      output dp_req_ready, dp_rsp_valid, dp_rsp_data,
      input  cfg_req_valid, cfg_req_we, cfg_req_addr, cfg_req_wdata,
      output cfg_req_ready, cfg_rsp_valid, cfg_rsp_data,
      input  clr_start,
      output busy, fsm_state,
      output ram_wea, ram_addra, ram_dina, ram_addrb,
      input  ram_doutb
   );

   modport master (
      output dp_req_valid, dp_req_we, dp_req_addr, dp_req_wdata,
      input  dp_req_ready, dp_rsp_valid, dp_rsp_data,
      output cfg_req_valid, cfg_req_we, cfg_req_addr, cfg_req_wdata,
      input  cfg_req_ready, cfg_rsp_valid, cfg_rsp_data,
      output clr_start,
      input  busy, fsm_state,
      input  ram_wea, ram_addra, ram_dina, ram_addrb,
      output ram_doutb
   );
endinterface

// File: rtl/alu_ram_arbiter.sv
// Arbitrates the datapath and config ports onto one simple dual-port RAM, returns read data
// in issue order to the requesting port, and zero-fills the RAM after reset or on command.
module alu_ram_arbiter #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter int RAM_LAT        = 2,
   parameter int CFG_STARVE_MAX = 4
) (
   input logic              clk,
   input logic              rst_n,
   alu_ram_arbiter_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(CFG_STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(CFG_STARVE_MAX);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_addr;
   logic [CNT_W-1:0]    starve_cnt;
   logic [RAM_LAT:0]    pipe_valid;
   logic [RAM_LAT:0]    pipe_src;
   logic                force_cfg, dp_ready, cfg_ready, busy_c;
   logic                dp_grant, cfg_grant, read_grant, write_grant;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   assign force_cfg   = (starve_cnt == STARVE_MAX);
   assign dp_grant    = bus.dp_req_valid & dp_ready;
   assign cfg_grant   = bus.cfg_req_valid & cfg_ready;
   assign read_grant  = (dp_grant & ~bus.dp_req_we) | (cfg_grant & ~bus.cfg_req_we);
   assign write_grant = (dp_grant & bus.dp_req_we) | (cfg_grant & bus.cfg_req_we);
   assign sel_addr    = cfg_grant ? bus.cfg_req_addr : bus.dp_req_addr;
   assign sel_wdata   = cfg_grant ? bus.cfg_req_wdata : bus.dp_req_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      dp_ready  = 1'b0;
      cfg_ready = 1'b0;
      case (state)
         CLEAR: begin
            busy_c = 1'b1;
            if (clr_addr == LAST_ADDR) state_nxt = SERVE;
         end
         SERVE: begin
            // dp has priority until cfg has waited long enough to be forced through
            dp_ready  = ~bus.clr_start & ~force_cfg;
            cfg_ready = ~bus.clr_start & (force_cfg | ~bus.dp_req_valid);
            if (bus.clr_start) state_nxt = CLEAR;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_addr   <= '0;
         starve_cnt <= '0;
      end else begin
         if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
         if (!bus.cfg_req_valid || cfg_grant) starve_cnt <= '0;
         else if (!force_cfg)                 starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ram_wea   <= 1'b0;
         bus.ram_addra <= '0;
         bus.ram_dina  <= '0;
         bus.ram_addrb <= '0;
      end else begin
         if (state == CLEAR) begin
            bus.ram_wea   <= 1'b1;
            bus.ram_addra <= clr_addr;
            bus.ram_dina  <= '0;
         end else if (write_grant) begin
            bus.ram_wea   <= 1'b1;
            bus.ram_addra <= sel_addr;
            bus.ram_dina  <= sel_wdata;
         end else begin
            bus.ram_wea   <= 1'b0;
         end
         if (read_grant) bus.ram_addrb <= sel_addr;
      end
   end

   // Stage k holds a read granted k+1 cycles ago; data is captured one stage before the pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid       <= '0;
         pipe_src         <= '0;
         bus.dp_rsp_data  <= '0;
         bus.cfg_rsp_data <= '0;
      end else begin
         pipe_valid <= {pipe_valid[RAM_LAT-1:0], read_grant};
         pipe_src   <= {pipe_src[RAM_LAT-1:0], cfg_grant};
         if (pipe_valid[RAM_LAT-1]) begin
            if (pipe_src[RAM_LAT-1]) bus.cfg_rsp_data <= bus.ram_doutb;
            else                     bus.dp_rsp_data  <= bus.ram_doutb;
         end
      end
   end

   assign bus.dp_rsp_valid  = pipe_valid[RAM_LAT] & ~pipe_src[RAM_LAT];
   assign bus.cfg_rsp_valid = pipe_valid[RAM_LAT] & pipe_src[RAM_LAT];
   assign bus.dp_req_ready  = dp_ready;
   assign bus.cfg_req_ready = cfg_ready;
   assign bus.busy          = busy_c;
   assign bus.fsm_state     = state;
endmodule

// File: tb/tb_alu_ram_arbiter.sv
// Directed bench for alu_ram_arbiter with a behavioural RAM and a per-port response scoreboard.
module tb_alu_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] exp_dp_q[$];
  int          exp_dp_cyc_q[$];
  logic [31:0] exp_cfg_q[$];
  int          exp_cfg_cyc_q[$];

  logic [31:0] mem [32];
  logic [31:0] ram_doutb = '0;

  alu_ram_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  alu_ram_arbiter #(.DATA_W(32), .ADDR_W(5), .RAM_LAT(2), .CFG_STARVE_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / cycle counter / RAM model (two edges from grant to read data)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
    ram_doutb <= mem[bus.ram_addrb];
  end
  assign bus.ram_doutb = ram_doutb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n && bus.dp_rsp_valid) begin
        if (exp_dp_q.size() == 0) chk("dp_rsp unexpected", 32'd1, 32'd0);
        else begin
          chk("dp_rsp data", bus.dp_rsp_data, exp_dp_q.pop_front());
          chk("dp_rsp cycle", cyc, exp_dp_cyc_q.pop_front());
        end
      end
      if (rst_n && bus.cfg_rsp_valid) begin
        if (exp_cfg_q.size() == 0) chk("cfg_rsp unexpected", 32'd1, 32'd0);
        else begin
          chk("cfg_rsp data", bus.cfg_rsp_data, exp_cfg_q.pop_front());
          chk("cfg_rsp cycle", cyc, exp_cfg_cyc_q.pop_front());
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic issue(input bit is_cfg, input bit we, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    bit granted = 0;
    int waited = 0;
    if (is_cfg) begin
      bus.cfg_req_valid = 1'b1; bus.cfg_req_we = we; bus.cfg_req_addr = addr; bus.cfg_req_wdata = wdata;
    end else begin
      bus.dp_req_valid = 1'b1; bus.dp_req_we = we; bus.dp_req_addr = addr; bus.dp_req_wdata = wdata;
    end
    while (!granted && waited < 100) begin
      @(negedge clk);
      if (is_cfg ? bus.cfg_req_ready : bus.dp_req_ready) begin
        granted = 1;
        if (!we) begin
          if (is_cfg) begin exp_cfg_q.push_back(exp); exp_cfg_cyc_q.push_back(cyc + 3); end
          else        begin exp_dp_q.push_back(exp);  exp_dp_cyc_q.push_back(cyc + 3);  end
        end
      end
      @(posedge clk); #1;
      waited++;
    end
    if (is_cfg) bus.cfg_req_valid = 1'b0;
    else        bus.dp_req_valid = 1'b0;
    if (!granted) chk("grant timeout", 32'd0, 32'd1);
  endtask

  task automatic check_clear(input string tag, input int exp_rsp);
    int bcnt = 0;
    int widx = 0;
    int rcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.ram_wea) begin
        chk({tag, " clear addr"}, 32'(bus.ram_addra), widx);
        chk({tag, " clear din"}, bus.ram_dina, 32'd0);
        widx++;
      end
      if (bus.dp_rsp_valid || bus.cfg_rsp_valid) rcnt++;
    end
    chk({tag, " busy cycles"}, bcnt, 32'd32);
    chk({tag, " clear writes"}, widx, 32'd32);
    chk({tag, " rsp during clear"}, rcnt, exp_rsp);
    chk({tag, " state serve"}, 32'(bus.fsm_state), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.dp_req_valid = 0; bus.dp_req_we = 0; bus.dp_req_addr = '0; bus.dp_req_wdata = '0;
    bus.cfg_req_valid = 0; bus.cfg_req_we = 0; bus.cfg_req_addr = '0; bus.cfg_req_wdata = '0;
    bus.clr_start = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst dp_ready", 32'(bus.dp_req_ready), 32'd0);
    chk("rst cfg_ready", 32'(bus.cfg_req_ready), 32'd0);
    chk("rst rsp_valid", 32'({bus.dp_rsp_valid, bus.cfg_rsp_valid}), 32'd0);
    chk("rst dp_rsp_data", bus.dp_rsp_data, 32'd0);
    chk("rst cfg_rsp_data", bus.cfg_rsp_data, 32'd0);
    chk("rst ram_wea", 32'(bus.ram_wea), 32'd0);
    chk("rst ram_addr", 32'({bus.ram_addra, bus.ram_addrb}), 32'd0);
    chk("rst ram_dina", bus.ram_dina, 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd1);
    chk("rst state", 32'(bus.fsm_state), 32'd0);
    fork monitor_loop(); join_none
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear("post-reset", 0);

    // cleared RAM reads back zero
    issue(1, 0, 5'd7, 32'd0, 32'd0);
    // write then read on the next cycle
    issue(0, 1, 5'd5, 32'hDEADBEEF, 32'd0);
    issue(0, 0, 5'd5, 32'd0, 32'hDEADBEEF);

    // preload and alternating back-to-back reads
    issue(0, 1, 5'd1, 32'h11, 32'd0);
    issue(1, 1, 5'd2, 32'h22, 32'd0);
    issue(0, 1, 5'd3, 32'h33, 32'd0);
    issue(1, 1, 5'd4, 32'h44, 32'd0);
    issue(0, 0, 5'd1, 32'd0, 32'h11);
    issue(1, 0, 5'd2, 32'd0, 32'h22);
    issue(0, 0, 5'd3, 32'd0, 32'h33);
    issue(1, 0, 5'd4, 32'd0, 32'h44);
    repeat (5) @(posedge clk); #1;

    // starvation: dp streams writes, cfg waits 4 cycles then is forced through
    bus.dp_req_valid = 1; bus.dp_req_we = 1; bus.dp_req_addr = 5'd20; bus.dp_req_wdata = 32'hA0;
    bus.cfg_req_valid = 1; bus.cfg_req_we = 0; bus.cfg_req_addr = 5'd5;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("starve dp_ready c%0d", i), 32'(bus.dp_req_ready), (i != 5) ? 32'd1 : 32'd0);
      chk($sformatf("starve cfg_ready c%0d", i), 32'(bus.cfg_req_ready), (i == 5) ? 32'd1 : 32'd0);
      if (i == 5) begin exp_cfg_q.push_back(32'hDEADBEEF); exp_cfg_cyc_q.push_back(cyc + 3); end
      @(posedge clk); #1;
    end
    bus.dp_req_valid = 0; bus.cfg_req_valid = 0;
    repeat (5) @(posedge clk); #1;

    // clear command with two reads in flight
    issue(0, 0, 5'd1, 32'd0, 32'h11);
    issue(1, 0, 5'd3, 32'd0, 32'h33);
    bus.clr_start = 1;
    bus.dp_req_valid = 1; bus.dp_req_we = 0; bus.dp_req_addr = 5'd4;
    @(negedge clk);
    chk("clr_start dp_ready", 32'(bus.dp_req_ready), 32'd0);
    chk("clr_start cfg_ready", 32'(bus.cfg_req_ready), 32'd0);
    @(posedge clk); #1;
    bus.clr_start = 0; bus.dp_req_valid = 0;
    check_clear("clr_start", 2);
    issue(0, 0, 5'd1, 32'd0, 32'd0);
    repeat (5) @(posedge clk); #1;

    // reset between a read grant and its response
    issue(0, 1, 5'd9, 32'h99, 32'd0);
    bus.cfg_req_valid = 1; bus.cfg_req_we = 0; bus.cfg_req_addr = 5'd9;
    @(negedge clk);
    chk("pre-reset cfg_ready", 32'(bus.cfg_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.cfg_req_valid = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear("mid-reset", 0);
    issue(1, 0, 5'd9, 32'd0, 32'd0);

    repeat (10) @(posedge clk); #1;
    chk("dp queue drained", exp_dp_q.size(), 32'd0);
    chk("cfg queue drained", exp_cfg_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
